// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the century-clock front-panel controller:
// mode encodings, digit-select geometry and small mode helpers.
package clock_ctrl_pkg;

    localparam logic [1:0] MODE_RUN_UP   = 2'b00;
    localparam logic [1:0] MODE_EDIT_INC = 2'b01;
    localparam logic [1:0] MODE_EDIT_DEC = 2'b10;
    localparam logic [1:0] MODE_RUN_DOWN = 2'b11;

    localparam int               SEL_W     = 6;
    localparam logic [SEL_W-1:0] SEL_RESET = 6'b000001;

    // Bit 0 is the mode button so the struct maps directly onto a raw 4-bit vector.
    typedef struct packed {
        logic down;
        logic up;
        logic next;
        logic mode;
    } btn_vec_t;

    function automatic logic is_edit(input logic [1:0] m);
        return (m == MODE_EDIT_INC) || (m == MODE_EDIT_DEC);
    endfunction

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/mode_select_ctrl_if.sv
// Panel-side bundle: ms timebase, raw buttons in, mode/select/strobes/LED out.
interface mode_select_ctrl_if;
    import clock_ctrl_pkg::*;

    logic             tick_ms;
    logic             btn_mode;
    logic             btn_next;
    logic             btn_up;
    logic             btn_down;
    logic [1:0]       mode;
    logic [SEL_W-1:0] select;
    logic             button_inc;
    logic             button_dec;
    logic             blink_led;

    modport master (
        output tick_ms, btn_mode, btn_next, btn_up, btn_down,
        input  mode, select, button_inc, button_dec, blink_led
    );

    modport slave (
        input  tick_ms, btn_mode, btn_next, btn_up, btn_down,
        output mode, select, button_inc, button_dec, blink_led
    );

endinterface

// File: rtl/btn_debounce.sv
// One button path: 2-flop synchroniser, tick-based debounce counter,
// accepted level and a one-clk press pulse on each accepted 0->1 change.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_ms,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (tick_ms) begin
            if (cnt_q != CW'(DEBOUNCE_MS)) cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DEBOUNCE_MS - 1)) acc_d = ~acc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            press_q <= acc_d & ~acc_q;
        end
    end

    assign level = acc_q;
    assign press = press_q;

endmodule

// File: rtl/mode_select_ctrl.sv
// Front-panel mode/digit-select controller for the century clock.
// Optional auto-repeat of up/down strobes is enabled by defining MODE_CTRL_REPEAT_EN.
module mode_select_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 20,
    parameter int TIMEOUT_MS      = 10000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int BLINK_MS        = 250
) (
    input  logic               clk,
    input  logic               reset,
    mode_select_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);

    logic [3:0] raw_vec, press_vec, level_vec;
    btn_vec_t   press, level;

    assign raw_vec = {bus.btn_down, bus.btn_up, bus.btn_next, bus.btn_mode};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn (
            .clk     (clk),
            .reset   (reset),
            .tick_ms (bus.tick_ms),
            .btn_raw (raw_vec[i]),
            .level   (level_vec[i]),
            .press   (press_vec[i])
        );
    end

    assign press = press_vec;
    assign level = level_vec;

    logic [1:0]       mode_q, mode_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic             inc_q, inc_d, dec_q, dec_d;
    logic             blink_q, blink_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             rep_strobe;
    logic             any_press;
    logic             unused_lvl;

    assign any_press = |press_vec;

`ifdef MODE_CTRL_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
    logic          rep_arm_q, rep_arm_d;
    logic          held;

    // First repeat after the delay, then one per rate period while still held.
    always_comb begin
        held       = ((mode_q == MODE_EDIT_INC) && level.up) ||
                     ((mode_q == MODE_EDIT_DEC) && level.down);
        rep_limit  = rep_arm_q ? RW'(REPEAT_RATE_MS) : RW'(REPEAT_DELAY_MS);
        rep_cnt_d  = rep_cnt_q;
        rep_arm_d  = rep_arm_q;
        rep_strobe = 1'b0;
        if (!held || press.mode) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (bus.tick_ms) begin
            if (rep_cnt_q == rep_limit - 1'b1) begin
                rep_strobe = 1'b1;
                rep_cnt_d  = '0;
                rep_arm_d  = 1'b1;
            end else if (rep_cnt_q != rep_limit) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end

    assign unused_lvl = level.mode ^ level.next;
`else
    assign rep_strobe = 1'b0;
    // Levels and repeat timings only feed the repeat logic; fold them into a dangling net.
    assign unused_lvl = ^{level, 32'(REPEAT_DELAY_MS), 32'(REPEAT_RATE_MS)};
`endif

    always_comb begin
        mode_d      = mode_q;
        select_d    = select_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        tmo_d       = tmo_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;

        if (press.mode) begin
            mode_d = next_mode(mode_q);
            if (!is_edit(mode_d) || (mode_q == MODE_RUN_UP)) select_d = SEL_RESET;
        end else if (is_edit(mode_q)) begin
            if (press.next) select_d = {select_q[SEL_W-2:0], select_q[SEL_W-1]};
            if ((mode_q == MODE_EDIT_INC) && (press.up || rep_strobe))   inc_d = 1'b1;
            if ((mode_q == MODE_EDIT_DEC) && (press.down || rep_strobe)) dec_d = 1'b1;
            if (bus.tick_ms && (tmo_q == TW'(TIMEOUT_MS - 1)) && !any_press && !rep_strobe) begin
                mode_d   = MODE_RUN_UP;
                select_d = SEL_RESET;
            end
        end else begin
            select_d = SEL_RESET;
        end

        if (!is_edit(mode_d) || any_press || rep_strobe || (mode_d != mode_q)) begin
            tmo_d = '0;
        end else if (bus.tick_ms && (tmo_q != TW'(TIMEOUT_MS))) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (!is_edit(mode_d)) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (bus.tick_ms) begin
            if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_RUN_UP;
            select_q    <= SEL_RESET;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            blink_q     <= 1'b0;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
        end else begin
            mode_q      <= mode_d;
            select_q    <= select_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            blink_q     <= blink_d;
            tmo_q       <= tmo_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign bus.mode       = mode_q;
    assign bus.select     = select_q;
    assign bus.button_inc = inc_q;
    assign bus.button_dec = dec_q;
    assign bus.blink_led  = blink_q;

endmodule

// File: doc/mode_select_ctrl.md
# mode_select_ctrl

Front-panel controller for the century clock. Conditions four raw push-buttons (synchronise, debounce, edge-detect) and runs the mode/digit-select state machine. Drives `mode`, `select`, `button_inc` and `button_dec` directly into the decode stage, which then fans out per-digit enables and inc/dec strobes to the counter chain.

## Interface
- `DEBOUNCE_MS`, default 20: consecutive `tick_ms` strobes a button level must hold before it is accepted.
- `TIMEOUT_MS`, default 10000: ticks with no accepted press in an edit mode before forced return to `RUN_UP`.
- `REPEAT_DELAY_MS`, default 500: hold time before auto-repeat starts.
- `REPEAT_RATE_MS`, default 100: auto-repeat period.
- `BLINK_MS`, default 250: half-period of `blink_led`.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `tick_ms`  in  1: one-`clk` strobe every 1 ms; the only timebase.
- `btn_mode`, `btn_next`, `btn_up`, `btn_down`  in  1 each: raw, asynchronous, active-high buttons.
- `mode`  out  2: 00 `RUN_UP`, 01 `EDIT_INC`, 10 `EDIT_DEC`, 11 `RUN_DOWN`.
- `select`  out  6: one-hot digit select, bit 0 = seconds.
- `button_inc`  out  1: one-`clk` increment strobe.
- `button_dec`  out  1: one-`clk` decrement strobe.
- `blink_led`  out  1: edit-mode indicator.

## Operation
- Each button path:
  - 2-flop synchroniser.
  - Debounce counter, cleared whenever the synced level equals the accepted state. It increments on `tick_ms` while the levels differ, and the accepted state flips on the tick where the count reaches `DEBOUNCE_MS`.
  - `press_*` pulses for one `clk` on a 0→1 change of the accepted state.
- Mode FSM advances on `press_mode`: `RUN_UP`→`EDIT_INC`→`EDIT_DEC`→`RUN_DOWN`→`RUN_UP`.
- Select rules:
  - Entering `EDIT_INC` from `RUN_UP` loads `select`=6'b000001.
  - `EDIT_INC`→`EDIT_DEC` keeps `select`.
  - In `RUN_UP`/`RUN_DOWN`, `select` is held at 6'b000001.
  - `press_next` in an edit mode rotates `select` left; 6'b100000 wraps to 6'b000001. It is ignored in run modes.
- Strobes:
  - `press_up` in `EDIT_INC` → `button_inc` pulse.
  - `press_down` in `EDIT_DEC` → `button_dec` pulse.
  - Up/down are ignored in all other modes.
  - `button_inc` and `button_dec` are never high together.
- Timeout: a tick counter runs in edit modes and is cleared by any `press_*` or mode change. On reaching `TIMEOUT_MS`: `mode`←`RUN_UP`, `select`←6'b000001.
- `blink_led` toggles every `BLINK_MS` ticks in edit modes. It is forced to 0, with the blink counter cleared, in run modes.
- Simultaneous events:
  - `press_mode` has priority; same-cycle next/up/down presses are dropped.
  - `press_next` and an up/down press in the same cycle are both honoured.
  - Timeout and any press in the same cycle: the press wins and the timeout counter clears.

## Timing
- Reset values: `mode`=2'b00, `select`=6'b000001, `button_inc`=`button_dec`=0, `blink_led`=0. All debounce, repeat, timeout and blink counters are 0 and all accepted states are 0.
- Press latency:
  - `press_*` is high in the `clk` after the accepted-state flip.
  - `mode`, `select`, `button_*` and `blink_led` are registered and change in the `clk` after `press_*`.
- Release needs `DEBOUNCE_MS` stable-low ticks and produces no strobe.
- Glitch shorter than `DEBOUNCE_MS` ticks: no accepted change, no output activity.
- Counter widths: each counter is `$clog2(param+1)` bits and saturates, never wrapping.
- Reset asserted mid-hold or mid-edit: all outputs return to reset values on the next edge. A button still held at reset release must re-debounce before it is accepted.

## Configuration
- `MODE_CTRL_REPEAT_EN` defined:
  - Holding up (in `EDIT_INC`) or down (in `EDIT_DEC`) with the accepted state high for `REPEAT_DELAY_MS` ticks emits an extra strobe.
  - After that, one strobe every `REPEAT_RATE_MS` ticks while held.
  - Each repeat strobe also clears the timeout counter.
  - The repeat counter clears on release or mode change.
- Macro undefined: one strobe per press only. The repeat counter and its parameters are unused and no repeat logic is synthesised.

## Structure
- Shared package `clock_ctrl_pkg`: mode encodings `MODE_RUN_UP`/`MODE_EDIT_INC`/`MODE_EDIT_DEC`/`MODE_RUN_DOWN`, `SEL_W`=6, `SEL_RESET`=6'b000001.
- Sub-module `btn_debounce` (synchroniser, debounce counter, accepted state, press pulse; parameter `DEBOUNCE_MS`), instantiated four times.
- FSM, select, repeat, timeout and blink logic live in the top module.

## Test plan
- Reset then idle 1000 ticks → `mode`=00, `select`=000001, no strobes, `blink_led`=0.
- `btn_mode` held 25 ticks → `mode`=01 one `clk` after `press_mode`. A 19-tick glitch → no change.
- In `EDIT_INC`, six `btn_next` presses → `select` 000010, 000100, 001000, 010000, 100000, 000001. Then `btn_up` press → exactly one `button_inc` pulse.
- In `EDIT_DEC`, press `btn_up` → no strobe. Press `btn_down` → one `button_dec`. Then 10000 idle ticks → `mode`=00, `select`=000001.
- With `MODE_CTRL_REPEAT_EN`, hold `btn_up` 1000 ticks in `EDIT_INC` → 1 + 1 + 4 = 6 `button_inc` pulses. Without the macro → 1 pulse.
- `btn_mode` and `btn_next` accepted in the same cycle in `EDIT_INC` → `mode`=10, `select` unchanged. Reset mid-hold → reset values, no strobe.
